uart_regload_rx: RTL and testbench
==================================

# uart_regload_rx

Serial-to-register-file loader: receives 8N1 UART frames on the board's UART_RXD line and turns two-byte commands into single-cycle write strobes for the 8×8-bit register file. It is the receiving end of the host link, the counterpart of our display/readback path. It lets a PC drive `write_address`/`write_data`/`write_enable` instead of SW and KEY. Runs entirely in the CLOCK_50 domain.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 4.
- iCLK  in  1  system clock (CLOCK_50).
- iRST_N  in  1  asynchronous active-low reset.
- rxd  in  1  raw UART line, asynchronous to iCLK, idle high.
- rx_byte  out  8  last received byte; held until the next byte.
- rx_valid  out  1  one-cycle pulse when rx_byte is updated.
- frame_err  out  1  one-cycle pulse on a bad stop bit (or bad parity, see Configuration).
- wr_en  out  1  one-cycle register-file write strobe.
- wr_addr  out  3  register address; held between strobes.
- wr_data  out  8  register data; held between strobes.
- busy  out  1  high whenever the bit FSM is not IDLE.

## Operation
- rxd passes through a 2-flop synchronizer before any use; both flops reset to 1.
- Bit FSM states are IDLE, START, DATA, PARITY (only with the macro), STOP and BREAK.
  - IDLE → START on a synchronized low; the bit counter clears.
  - START: after CLKS_PER_BIT/2 cycles, samples the line. If low → DATA. If high → IDLE (glitch; no pulse).
  - DATA: samples every CLKS_PER_BIT cycles, at the bit centre, 8 bits, LSB first, into a shift register.
  - STOP: samples after CLKS_PER_BIT cycles.
    - If high: rx_byte is loaded, rx_valid pulses, and the FSM returns to IDLE.
    - If low: frame_err pulses, no rx_valid, and the FSM goes to BREAK.
  - BREAK: waits for a synchronized high, then → IDLE.
- Command assembler, with phases ADDR and DATA:
  - ADDR: a valid byte with bits [7:3] = 5'b10100 (0xA0–0xA7) latches bits [2:0] as the pending address and moves to DATA. Any other byte is discarded and the phase stays ADDR.
  - DATA: the next valid byte is the data.
    - wr_addr ← pending address and wr_data ← byte, in the same clock edge.
    - wr_en pulses for one cycle.
    - The phase returns to ADDR.
  - Any frame_err forces the phase to ADDR, dropping the pending address.
- Reset values: rx_byte=0, rx_valid=0, frame_err=0, wr_en=0, wr_addr=0, wr_data=0, busy=0; FSM in IDLE, assembler in ADDR.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is lost, and the rest of it is treated as new line activity.

## Timing
- Start edge to start-bit mid-sample: 2 synchronizer cycles + CLKS_PER_BIT/2 (integer division).
- Stop-bit sample to rx_valid: 1 cycle (registered).
- rx_valid of the data byte to wr_en: 1 cycle. wr_addr/wr_data change on the same edge as wr_en rises.
- rx_valid and frame_err are never high in the same cycle.
- A new start bit is accepted on the cycle after the return to IDLE. Back-to-back frames with a one-bit stop are supported without loss.
- Bit counter width is $clog2(CLKS_PER_BIT); its wrap point is CLKS_PER_BIT−1.

## Configuration
- UART_REGLOAD_PARITY_EN defined:
  - Frame is 8E1: the PARITY state samples a ninth bit after the data bits.
  - If the data bits plus the parity bit are not even, the byte is still framed through STOP but frame_err pulses instead of rx_valid. If the stop bit is low, the BREAK path applies as usual.
- Undefined: the frame is 8N1 and the PARITY state does not exist.

## Structure
- Shared package uart_pkg holds:
  - the bit-FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the assembler phase enum;
  - the constants CMD_ADDR_TAG = 5'b10100 and DATA_BITS = 8.
- Sub-module uart_rx_core implements the synchronizer, the bit FSM, rx_byte, rx_valid, frame_err and busy. The top level adds the command assembler and write outputs.

## Test plan
All scenarios use CLKS_PER_BIT = 8.
- Reset: hold iRST_N low with rxd = 1 → all outputs 0. After release with no activity, wr_en stays 0 for 1000 cycles.
- Single write: send 0xA5 then 0x3C → rx_valid twice; wr_en pulses once with wr_addr=5 and wr_data=0x3C; wr_en rises exactly 1 cycle after the second rx_valid.
- Bad tag: send 0x42 then 0x11 → rx_valid twice, no wr_en. A following 0xA1, 0xFF writes address 1 with 0xFF.
- Framing error: send 0xA2, then a byte with stop bit 0 held low for 20 bit-times, then 0x77 → frame_err pulses once, busy stays high until the line rises, and 0x77 is treated as an address byte (discarded, no wr_en).
- Glitch: drive rxd low for 3 cycles → busy pulses, no rx_valid and no frame_err.
- Mid-frame reset: assert iRST_N during bit 4 of 0xA3, then send 0xA6, 0x09 → the only write is address 6 with 0x09. With UART_REGLOAD_PARITY_EN defined, a wrong parity bit on 0x09 gives frame_err and no wr_en.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART register-file loader.
// Optional feature macro: UART_REGLOAD_PARITY_EN (8E1 framing when defined).
package uart_pkg;

    // Bit-level receive FSM states. ST_PARITY is only reachable with parity enabled.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Two-byte command assembler phases.
    typedef enum logic {
        PH_ADDR,
        PH_DATA
    } asm_phase_e;

    localparam logic [4:0] CMD_ADDR_TAG = 5'b10100;
    localparam int         DATA_BITS    = 8;

    // True when a byte is an address command (0xA0-0xA7).
    function automatic logic is_addr_byte(input logic [DATA_BITS-1:0] b);
        return (b[7:3] == CMD_ADDR_TAG);
    endfunction

endpackage

// File: rtl/uart_regload_rx_if.sv
// Signal bundle between the UART loader and its environment.
// master: the loader side (drives the register-file write bus, consumes rxd).
// slave:  the environment side (drives rxd, observes everything else).
interface uart_regload_rx_if;
    logic       rxd;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    modport master (
        input  rxd,
        output rx_byte, rx_valid, frame_err, wr_en, wr_addr, wr_data, busy
    );

    modport slave (
        output rxd,
        input  rx_byte, rx_valid, frame_err, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop synchronizer, bit FSM, received byte and pulses.
// Frame is 8N1 by default, 8E1 when UART_REGLOAD_PARITY_EN is defined.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic [1:0]           sync_q, sync_d;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_s;
    logic                 par_bad;

    assign sync_d = {sync_q[0], rxd};
    assign rx_s   = sync_q[1];

`ifdef UART_REGLOAD_PARITY_EN
    logic par_err_q, par_err_d;
    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    // Register the synchronizer (idle-high reset), FSM state, counters and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_REGLOAD_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_REGLOAD_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    // Bit FSM: start qualification at half a bit, then one sample per bit centre.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_REGLOAD_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    // A line that is high again at mid-start was only a glitch.
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_REGLOAD_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_REGLOAD_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    // Even parity: data bits plus parity bit must XOR to zero.
                    par_err_d = ^{shift_q, rx_s};
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        if (par_bad) begin
                            frame_err_d = 1'b1;
                        end else begin
                            rx_byte_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_regload_rx.sv
// UART register-file loader top: receiver core plus two-byte command assembler.
// Command = address byte 0xA0-0xA7 followed by a data byte -> one write strobe.
// Optional feature macro: UART_REGLOAD_PARITY_EN (handled inside uart_rx_core).
module uart_regload_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    uart_regload_rx_if.master  bus
);

    logic [DATA_BITS-1:0] rx_byte_w;
    logic                 rx_valid_w;
    logic                 frame_err_w;
    logic                 busy_w;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk       (iCLK),
        .rst_n     (iRST_N),
        .rxd       (bus.rxd),
        .rx_byte   (rx_byte_w),
        .rx_valid  (rx_valid_w),
        .frame_err (frame_err_w),
        .busy      (busy_w)
    );

    asm_phase_e           phase_q, phase_d;
    logic [2:0]           pend_addr_q, pend_addr_d;
    logic                 wr_en_q, wr_en_d;
    logic [2:0]           wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;

    // Register assembler phase, pending address and the write bus.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            phase_q     <= PH_ADDR;
            pend_addr_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            phase_q     <= phase_d;
            pend_addr_q <= pend_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Pair an address byte with the next data byte; a framing error resynchronizes.
    always_comb begin
        phase_d     = phase_q;
        pend_addr_d = pend_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (frame_err_w) begin
            phase_d     = PH_ADDR;
            pend_addr_d = '0;
        end else if (rx_valid_w) begin
            case (phase_q)
                PH_ADDR: begin
                    if (is_addr_byte(rx_byte_w)) begin
                        pend_addr_d = rx_byte_w[2:0];
                        phase_d     = PH_DATA;
                    end
                end
                PH_DATA: begin
                    wr_addr_d = pend_addr_q;
                    wr_data_d = rx_byte_w;
                    wr_en_d   = 1'b1;
                    phase_d   = PH_ADDR;
                end
                default: begin
                    phase_d = PH_ADDR;
                end
            endcase
        end
    end

    assign bus.rx_byte   = rx_byte_w;
    assign bus.rx_valid  = rx_valid_w;
    assign bus.frame_err = frame_err_w;
    assign bus.busy      = busy_w;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_uart_regload_rx.sv
// Directed bench for uart_regload_rx with CLKS_PER_BIT = 8.
// Expected bytes and writes are queued as frames are sent and checked when
// the DUT pulses rx_valid / wr_en. Honours UART_REGLOAD_PARITY_EN.
module tb_uart_regload_rx;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_regload_rx_if bus_if ();

    uart_regload_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int rx_cnt   = 0;
    int wr_cnt   = 0;
    int fe_cnt   = 0;
    int exp_fe   = 0;
    int exp_wr_total = 0;
    bit ignore_rx = 1'b0;
    bit prev_rxv  = 1'b0;

    logic [7:0]  exp_rx[$];
    logic [10:0] exp_wr[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_len);
        bus_if.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus_if.rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_REGLOAD_PARITY_EN
        bus_if.rxd = ^b;
        repeat (CPB) @(negedge clk);
`endif
        bus_if.rxd = stop_val;
        repeat (CPB * stop_len) @(negedge clk);
        bus_if.rxd = 1'b1;
    endtask

`ifdef UART_REGLOAD_PARITY_EN
    task automatic send_bad_parity(input logic [7:0] b);
        bus_if.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus_if.rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus_if.rxd = ~(^b);
        repeat (CPB) @(negedge clk);
        bus_if.rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask
`endif

    task automatic send_good(input logic [7:0] b);
        exp_rx.push_back(b);
        send_byte(b, 1'b1, 1);
    endtask

    // Monitor: one line per received byte / write, compared against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.rx_valid) begin
                rx_cnt++;
                $display("[%0t] rx_byte %02h%s", $time, bus_if.rx_byte, ignore_rx ? " (ignored)" : "");
                if (!ignore_rx) begin
                    check("rx_expected", 32'(exp_rx.size() > 0), 32'd1);
                    if (exp_rx.size() > 0) begin
                        check("rx_byte", 32'(bus_if.rx_byte), 32'(exp_rx.pop_front()));
                    end
                    check("rx_fe_excl", 32'(bus_if.frame_err), 32'd0);
                end
            end
            if (bus_if.frame_err && !ignore_rx) begin
                fe_cnt++;
                $display("[%0t] frame_err", $time);
            end
            if (bus_if.wr_en) begin
                wr_cnt++;
                $display("[%0t] write addr %0d data %02h", $time, bus_if.wr_addr, bus_if.wr_data);
                check("wr_latency", 32'(prev_rxv), 32'd1);
                check("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    check("wr_addr_data", 32'({bus_if.wr_addr, bus_if.wr_data}), 32'(exp_wr.pop_front()));
                end
            end
        end
        prev_rxv = rst_n && bus_if.rx_valid;
    end

    initial begin
        logic [7:0] a3;
        int rx_before;
        int fe_before;
        bit busy_seen;
        a3 = 8'hA3;
        bus_if.rxd = 1'b1;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_rx_byte",   32'(bus_if.rx_byte),   32'd0);
        check("rst_rx_valid",  32'(bus_if.rx_valid),  32'd0);
        check("rst_frame_err", 32'(bus_if.frame_err), 32'd0);
        check("rst_wr_en",     32'(bus_if.wr_en),     32'd0);
        check("rst_wr_addr",   32'(bus_if.wr_addr),   32'd0);
        check("rst_wr_data",   32'(bus_if.wr_data),   32'd0);
        check("rst_busy",      32'(bus_if.busy),      32'd0);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_no_wr", 32'(wr_cnt), 32'd0);
        check("idle_no_rx", 32'(rx_cnt), 32'd0);

        // Single write, back-to-back frames
        send_good(8'hA5);
        exp_wr.push_back({3'd5, 8'h3C}); exp_wr_total++;
        send_good(8'h3C);
        repeat (4 * CPB) @(negedge clk);
        check("single_wr_cnt", 32'(wr_cnt), 32'd1);

        // Bad tag is discarded, then a valid command
        send_good(8'h42);
        send_good(8'h11);
        repeat (2 * CPB) @(negedge clk);
        check("badtag_no_wr", 32'(wr_cnt), 32'd1);
        send_good(8'hA1);
        exp_wr.push_back({3'd1, 8'hFF}); exp_wr_total++;
        send_good(8'hFF);
        repeat (4 * CPB) @(negedge clk);

        // Framing error with long break, then 0x77 must be an address byte
        send_good(8'hA2);
        send_byte(8'h55, 1'b0, 20);
        exp_fe++;
        check("break_busy", 32'(bus_if.busy), 32'd1);
        repeat (6) @(negedge clk);
        check("break_released", 32'(bus_if.busy), 32'd0);
        check("fe_count", 32'(fe_cnt), 32'(exp_fe));
        send_good(8'h77);
        repeat (4 * CPB) @(negedge clk);
        check("fe_no_wr", 32'(wr_cnt), 32'd2);

        // Glitch: short low pulse
        rx_before = rx_cnt;
        fe_before = fe_cnt;
        busy_seen = 1'b0;
        bus_if.rxd = 1'b0;
        repeat (3) @(negedge clk);
        bus_if.rxd = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            busy_seen |= bus_if.busy;
        end
        check("glitch_busy", 32'(busy_seen), 32'd1);
        check("glitch_no_rx", 32'(rx_cnt), 32'(rx_before));
        check("glitch_no_fe", 32'(fe_cnt), 32'(fe_before));
        check("glitch_idle", 32'(bus_if.busy), 32'd0);

        // Mid-frame reset during bit 4 of 0xA3
        bus_if.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus_if.rxd = a3[i];
            repeat (CPB) @(negedge clk);
        end
        bus_if.rxd = a3[4];
        repeat (CPB / 2) @(negedge clk);
        ignore_rx = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",    32'(bus_if.busy),    32'd0);
        check("mid_rst_wr_addr", 32'(bus_if.wr_addr), 32'd0);
        check("mid_rst_wr_data", 32'(bus_if.wr_data), 32'd0);
        check("mid_rst_rx_byte", 32'(bus_if.rx_byte), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB / 2 - 2) @(negedge clk);
        for (int i = 5; i < 8; i++) begin
            bus_if.rxd = a3[i];
            repeat (CPB) @(negedge clk);
        end
        bus_if.rxd = 1'b1;
        repeat (16 * CPB) @(negedge clk);
        ignore_rx = 1'b0;
        send_good(8'hA6);
        exp_wr.push_back({3'd6, 8'h09}); exp_wr_total++;
        send_good(8'h09);
        repeat (4 * CPB) @(negedge clk);

`ifdef UART_REGLOAD_PARITY_EN
        // Wrong parity on the data byte: frame_err, no write
        send_good(8'hA6);
        send_bad_parity(8'h09);
        exp_fe++;
        repeat (4 * CPB) @(negedge clk);
        check("parity_fe", 32'(fe_cnt), 32'(exp_fe));
`endif

        // Final scoreboard state
        check("final_wr_cnt", 32'(wr_cnt), 32'(exp_wr_total));
        check("final_fe_cnt", 32'(fe_cnt), 32'(exp_fe));
        check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
